// File: rtl/decode_queue.sv
// decode_queue: instruction queue of DEPTH entries in front of a registered
// RV64I decoder, with valid/ready handshakes on the fetch and issue sides.
//
// Optional feature macro: DECODE_MEXT_EN. When it is defined, OP/OP-32 with
// funct7=0000001 decode as M-extension ops. When it is undefined, that
// funct7 is illegal and is_muldiv_o stays 0.
//
// Ports
//   clk_i, rst_i            clock, asynchronous active-high reset
//   flush_i                 synchronous discard of queue and output register
//   in_valid_i/in_ready_o   fetch handshake; in_instr_i, in_pc_i payload
//   count_o                 queue occupancy (output register excluded)
//   out_valid_o/out_ready_i issue handshake
//   out_pc_o, rs*/rd        PC and register fields of decoded instruction
//   alu_op_o/lsu_op_o/branch_op_o   operation selects (riscv_pkg encodings)
//   reg_write_o .. illegal_o        datapath controls and flags
//   imm_o                   sign-extended immediate
package riscv_pkg;
    typedef enum logic [3:0] {
        ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU,
        ALU_XOR, ALU_SRL, ALU_SRA, ALU_OR, ALU_AND
    } alu_op_t;
    typedef enum logic [3:0] {
        LSU_NONE, LSU_LB, LSU_LH, LSU_LW, LSU_LD, LSU_LBU, LSU_LHU, LSU_LWU,
        LSU_SB, LSU_SH, LSU_SW, LSU_SD
    } lsu_op_t;
    typedef enum logic [2:0] {
        BR_NONE, BR_BEQ, BR_BNE, BR_BLT, BR_BGE, BR_BLTU, BR_BGEU
    } br_op_t;
endpackage

module decode_queue #(
    parameter int DEPTH = 4,
    parameter int XLEN  = 64
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic                     flush_i,
    input  logic                     in_valid_i,
    output logic                     in_ready_o,
    input  logic [31:0]              in_instr_i,
    input  logic [XLEN-1:0]          in_pc_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     out_valid_o,
    input  logic                     out_ready_i,
    output logic [XLEN-1:0]          out_pc_o,
    output logic [4:0]               rs1_addr_o,
    output logic [4:0]               rs2_addr_o,
    output logic [4:0]               rd_addr_o,
    output logic [3:0]               alu_op_o,
    output logic [3:0]               lsu_op_o,
    output logic [2:0]               branch_op_o,
    output logic                     reg_write_o,
    output logic                     alu_src_o,
    output logic                     mem_write_o,
    output logic                     mem_read_o,
    output logic                     mem_to_reg_o,
    output logic                     is_jump_o,
    output logic                     is_jalr_o,
    output logic                     is_lui_o,
    output logic                     is_auipc_o,
    output logic                     is_word_o,
    output logic                     is_muldiv_o,
    output logic                     illegal_o,
    output logic [XLEN-1:0]          imm_o
);
    import riscv_pkg::*;

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;
    localparam logic [CW-1:0] DEPTH_C = CW'(DEPTH);

    typedef struct packed {
        logic [4:0]      rs1, rs2, rd;
        alu_op_t         alu_op;
        lsu_op_t         lsu_op;
        br_op_t          br_op;
        logic            reg_write, alu_src, mem_write, mem_read, mem_to_reg;
        logic            is_jump, is_jalr, is_lui, is_auipc, is_word, is_muldiv;
        logic            illegal;
        logic [XLEN-1:0] imm;
    } dec_t;

    function automatic alu_op_t alu_from_f3(input logic [2:0] f3, input logic alt);
        case (f3)
            3'b000:  return alt ? ALU_SUB : ALU_ADD;
            3'b001:  return ALU_SLL;
            3'b010:  return ALU_SLT;
            3'b011:  return ALU_SLTU;
            3'b100:  return ALU_XOR;
            3'b101:  return alt ? ALU_SRA : ALU_SRL;
            3'b110:  return ALU_OR;
            default: return ALU_AND;
        endcase
    endfunction

    function automatic dec_t decode(input logic [31:0] instr);
        dec_t d;
        logic [6:0] f7;
        logic [2:0] f3;
        logic ill;
        logic signed [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
        d = '0;
        f7 = instr[31:25];
        f3 = instr[14:12];
        imm_i = XLEN'($signed(instr[31:20]));
        imm_s = XLEN'($signed({instr[31:25], instr[11:7]}));
        imm_b = XLEN'($signed({instr[31], instr[7], instr[30:25], instr[11:8], 1'b0}));
        imm_j = XLEN'($signed({instr[31], instr[19:12], instr[20], instr[30:21], 1'b0}));
        imm_u = XLEN'($signed({instr[31:12], 12'b0}));
        d.rd  = instr[11:7];
        d.rs1 = instr[19:15];
        d.rs2 = instr[24:20];
        ill = (instr[1:0] != 2'b11);
        case (instr[6:0])
            7'b0110111: begin d.reg_write = 1'b1; d.alu_src = 1'b1; d.is_lui = 1'b1; d.imm = imm_u; end
            7'b0010111: begin d.reg_write = 1'b1; d.alu_src = 1'b1; d.is_auipc = 1'b1; d.imm = imm_u; end
            7'b1101111: begin d.reg_write = 1'b1; d.is_jump = 1'b1; d.imm = imm_j; end
            7'b1100111: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1; d.is_jump = 1'b1; d.is_jalr = 1'b1;
                d.imm = imm_i;
                ill = ill | (f3 != 3'b000);
            end
            7'b1100011: begin
                d.alu_op = ALU_SUB;
                d.imm = imm_b;
                case (f3)
                    3'b000: d.br_op = BR_BEQ;
                    3'b001: d.br_op = BR_BNE;
                    3'b100: d.br_op = BR_BLT;
                    3'b101: d.br_op = BR_BGE;
                    3'b110: d.br_op = BR_BLTU;
                    3'b111: d.br_op = BR_BGEU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0000011: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1; d.mem_read = 1'b1; d.mem_to_reg = 1'b1;
                d.imm = imm_i;
                case (f3)
                    3'b000: d.lsu_op = LSU_LB;
                    3'b001: d.lsu_op = LSU_LH;
                    3'b010: d.lsu_op = LSU_LW;
                    3'b011: d.lsu_op = LSU_LD;
                    3'b100: d.lsu_op = LSU_LBU;
                    3'b101: d.lsu_op = LSU_LHU;
                    3'b110: d.lsu_op = LSU_LWU;
                    default: ill = 1'b1;
                endcase
            end
            7'b0100011: begin
                d.alu_src = 1'b1; d.mem_write = 1'b1;
                d.imm = imm_s;
                case (f3)
                    3'b000: d.lsu_op = LSU_SB;
                    3'b001: d.lsu_op = LSU_SH;
                    3'b010: d.lsu_op = LSU_SW;
                    3'b011: d.lsu_op = LSU_SD;
                    default: ill = 1'b1;
                endcase
            end
            7'b0010011: begin
                // RV64 shifts carry a 6-bit shamt, so only funct7[6:1] is an opcode field
                d.reg_write = 1'b1; d.alu_src = 1'b1; d.imm = imm_i;
                d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                if (f3 == 3'b001) ill = ill | (instr[31:26] != 6'b000000);
                if (f3 == 3'b101) ill = ill | ((instr[31:26] != 6'b000000) && (instr[31:26] != 6'b010000));
            end
            7'b0011011: begin
                d.reg_write = 1'b1; d.alu_src = 1'b1; d.is_word = 1'b1; d.imm = imm_i;
                d.alu_op = alu_from_f3(f3, (f3 == 3'b101) && instr[30]);
                case (f3)
                    3'b000: ;
                    3'b001: ill = ill | (f7 != 7'b0000000);
                    3'b101: ill = ill | ((f7 != 7'b0000000) && (f7 != 7'b0100000));
                    default: ill = 1'b1;
                endcase
            end
            7'b0110011, 7'b0111011: begin
                d.reg_write = 1'b1;
                d.is_word = instr[3];
                d.alu_op = alu_from_f3(f3, f7 == 7'b0100000);
                if (f7 == 7'b0000000)
                    ill = ill | (instr[3] && !(f3 == 3'b000 || f3 == 3'b001 || f3 == 3'b101));
                else if (f7 == 7'b0100000)
                    ill = ill | !(f3 == 3'b000 || f3 == 3'b101);
`ifdef DECODE_MEXT_EN
                else if (f7 == 7'b0000001) begin
                    d.is_muldiv = 1'b1;
                    d.alu_op = ALU_ADD;
                    ill = ill | (instr[3] && (f3 == 3'b001 || f3 == 3'b010 || f3 == 3'b011));
                end
`endif
                else
                    ill = 1'b1;
            end
            default: ill = 1'b1;
        endcase
        // Illegal instructions still travel to issue for trap handling but
        // must not cause any architectural side effect.
        if (ill) begin
            d.reg_write = 1'b0; d.mem_write = 1'b0; d.mem_read = 1'b0;
            d.is_jump = 1'b0; d.is_muldiv = 1'b0;
        end
        d.illegal = ill;
        return d;
    endfunction

    logic [31:0]     instr_mem [DEPTH];
    logic [XLEN-1:0] pc_mem    [DEPTH];
    logic [AW-1:0]   rd_ptr, wr_ptr;
    logic [CW-1:0]   count;

    logic            push, advance, enq, deq, src_avail;
    logic [31:0]     src_instr;
    logic [XLEN-1:0] src_pc;
    dec_t            dec_p0, dec_p1;
    logic [XLEN-1:0] pc_p1;
    logic            vld_p1;

    assign in_ready_o = (count < DEPTH_C) && !flush_i && !rst_i;
    assign push       = in_valid_i && in_ready_o;
    assign advance    = !vld_p1 || out_ready_i;
    // With an empty queue the incoming word bypasses storage straight into decode
    assign deq        = advance && (count != '0);
    assign enq        = push && !(advance && (count == '0));
    assign src_avail  = (count != '0) || push;
    assign src_instr  = (count != '0) ? instr_mem[rd_ptr] : in_instr_i;
    assign src_pc     = (count != '0) ? pc_mem[rd_ptr] : in_pc_i;
    assign dec_p0     = decode(src_instr);

    always_ff @(posedge clk_i) begin
        if (enq) begin
            instr_mem[wr_ptr] <= in_instr_i;
            pc_mem[wr_ptr]    <= in_pc_i;
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else if (flush_i) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (enq) wr_ptr <= wr_ptr + 1'b1;
            if (deq) rd_ptr <= rd_ptr + 1'b1;
            count <= count + CW'(enq) - CW'(deq);
        end
    end

    // ---- stage p0 -> p1: decoded output register ----
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            vld_p1 <= 1'b0;
            pc_p1  <= '0;
            dec_p1 <= '0;
        end else if (flush_i) begin
            vld_p1 <= 1'b0;
        end else if (advance) begin
            vld_p1 <= src_avail;
            if (src_avail) begin
                pc_p1  <= src_pc;
                dec_p1 <= dec_p0;
            end
        end
    end

    assign count_o      = count;
    assign out_valid_o  = vld_p1;
    assign out_pc_o     = pc_p1;
    assign rs1_addr_o   = dec_p1.rs1;
    assign rs2_addr_o   = dec_p1.rs2;
    assign rd_addr_o    = dec_p1.rd;
    assign alu_op_o     = dec_p1.alu_op;
    assign lsu_op_o     = dec_p1.lsu_op;
    assign branch_op_o  = dec_p1.br_op;
    assign reg_write_o  = dec_p1.reg_write;
    assign alu_src_o    = dec_p1.alu_src;
    assign mem_write_o  = dec_p1.mem_write;
    assign mem_read_o   = dec_p1.mem_read;
    assign mem_to_reg_o = dec_p1.mem_to_reg;
    assign is_jump_o    = dec_p1.is_jump;
    assign is_jalr_o    = dec_p1.is_jalr;
    assign is_lui_o     = dec_p1.is_lui;
    assign is_auipc_o   = dec_p1.is_auipc;
    assign is_word_o    = dec_p1.is_word;
    assign is_muldiv_o  = dec_p1.is_muldiv;
    assign illegal_o    = dec_p1.illegal;
    assign imm_o        = dec_p1.imm;
endmodule

// File: doc/decode_queue.md
# decode_queue

Parametrised decode stage: an instruction queue of DEPTH entries in front of a registered RV64I decoder, with valid/ready handshakes on both sides. It sits between fetch and issue/execute, absorbing fetch bursts and stalls. It adds RV64 word ops (OP-IMM-32/OP-32), illegal-instruction detection, and optional M-extension decode. Decoded fields are presented from a single output register.

## Interface
- DEPTH, 4, queue entries; power of two, ≥2
- XLEN, 64, PC/immediate width
- clk_i  input  1  clock
- rst_i  input  1  reset; asynchronous, active-high
- flush_i  input  1  synchronous discard of queue and output register
- in_valid_i  input  1  fetch has an instruction
- in_ready_o  output  1  queue can accept; = (count_o < DEPTH) && !flush_i && !rst_i
- in_instr_i  input  32  instruction word
- in_pc_i  input  XLEN  instruction PC
- count_o  output  $clog2(DEPTH)+1  queue occupancy (output register excluded)
- out_valid_o  output  1  output register holds a decoded instruction
- out_ready_i  input  1  consumer accepts
- out_pc_o  output  XLEN  PC of decoded instruction
- rs1_addr_o / rs2_addr_o / rd_addr_o  output  5 each  register fields
- alu_op_o / lsu_op_o / branch_op_o  output  riscv_pkg enums  operation selects
- reg_write_o, alu_src_o, mem_write_o, mem_read_o, mem_to_reg_o  output  1 each  datapath controls
- is_jump_o, is_jalr_o, is_lui_o, is_auipc_o  output  1 each  operand/PC select flags
- is_word_o  output  1  32-bit op; result sign-extended from bit 31
- is_muldiv_o  output  1  M-extension op; funct3 selects MUL/DIV variant
- illegal_o  output  1  instruction is illegal
- imm_o  output  XLEN  sign-extended immediate (I/S/B/J/U formats)

## Operation
- Push: in_valid_i && in_ready_o at a rising edge. Pop: out_valid_o && out_ready_i.
- Output register loads when empty or popped in the same cycle (advance). Source: queue head if count_o>0; otherwise bypass, decoding in_instr_i directly (queue untouched). Program order always preserved.
- Queue is a circular buffer; read/write pointers wrap modulo DEPTH. Simultaneous push and pop when non-empty: count unchanged.
- in_ready_o does not depend on out_ready_i. At full, no push occurs even when a pop occurs that cycle.
- Decode: RV64I as in the existing scalar decoder, plus OP-IMM-32 (0011011) and OP-32 (0111011) with is_word_o=1. ALU op mapping is identical; alu_src_o=1 for OP-IMM-32.
- Illegal when any of: instr[1:0]≠11; unknown opcode; load funct3=111; store funct3[2]=1; branch funct3 010/011; JALR funct3≠0; OP/OP-32 funct7 not 0000000, or 0100000 with funct3 000/101; OP-IMM shift funct7[6:1] not 000000/010000 (010000 only for funct3 101); OP-IMM-32 shift funct7 not 0000000/0100000; *-32 funct3 not in {000,001,101} (OP-IMM-32 shifts) or {000,001,101} (OP-32).
- Illegal instructions: illegal_o=1; reg_write_o, mem_write_o, mem_read_o, is_jump_o, is_muldiv_o forced 0; still delivered with out_valid_o=1 for trap handling.
- flush_i: next edge clears pointers, count_o→0, out_valid_o→0. No push that cycle. Pop handshake in the flush cycle is ignored by the block.

## Timing
- Reset: count_o=0, out_valid_o=0, all decoded outputs and out_pc_o 0, pointers 0. in_ready_o=0 while rst_i is high and 1 on the first cycle after release.
- Latency: with an empty queue and an advancing output register, a push at edge N gives out_valid_o=1 after edge N. Via queue: one cycle after reaching the head and the output advancing.
- Throughput: 1 instruction/cycle sustained. Capacity: DEPTH+1 in flight.
- Outputs hold stable while out_valid_o && !out_ready_i.
- Reset asserted mid-operation returns all state to reset values immediately; in-flight instructions are lost.

## Configuration
- DECODE_MEXT_EN defined: OP/OP-32 with funct7=0000001 decode as M ops: is_muldiv_o=1, reg_write_o=1, alu_op_o=ALU_ADD (ignored downstream). OP-32 accepts funct3 000,100–111 only; others illegal.
- Undefined: is_muldiv_o tied 0; funct7=0000001 is illegal.

## Test plan
- Bypass: empty, out_ready_i=1, push 0x00500093 (addi x1,x0,5) → next cycle out_valid_o=1, rd=1, rs1=0, imm_o=5, alu_src_o=1, reg_write_o=1, count_o=0.
- Fill/backpressure: DEPTH=4, out_ready_i=0, push 6 back-to-back → first 5 accepted, in_ready_o=0 with count_o=4. Release out_ready_i → 5 outputs in order, one per cycle, PCs ascending.
- Word op: push 0x0010009B (addiw x1,x0,1) → is_word_o=1, alu_op_o=ALU_ADD, imm_o=1. Push 0x4000D0BB (sraw) → ALU_SRA, is_word_o=1.
- Illegal: push 0x00000000 and 0x0000707B → illegal_o=1, reg_write_o=0, mem_write_o=0, out_valid_o=1.
- M-ext: push 0x02208033 (mul x0,x1,x2) → with DECODE_MEXT_EN: is_muldiv_o=1, illegal_o=0. Without: illegal_o=1.
- Flush/reset: 3 queued plus output valid, assert flush_i concurrent with in_valid_i → next cycle count_o=0, out_valid_o=0, nothing accepted. Repeat with rst_i pulse mid-stream → same result asynchronously.
